step_counter: RTL and testbench

Parametrised up/down counter for general-purpose event and cycle counting in the common library, extending the basic enable/clear counter. Adds:
- programmable step and terminal value (MAX),
- direction control,
- parallel load,
- wrap or saturate mode,
- a terminal-count pulse and a sticky overflow flag.

Intended for timers, address generators and loop counters in datapath blocks.

---
 rtl/step_counter.sv | 83 ++++++++
 tb/tb_step_counter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/step_counter.sv
// Up/down step counter with a programmable terminal value and wrap or saturate limiting.
// It raises a registered terminal-count pulse and a sticky overflow flag on boundary events.
module step_counter #(
    parameter int unsigned COUNTER_WIDTH = 8,
    parameter int unsigned RESET_VAL     = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic                     load_i,
    input  logic [COUNTER_WIDTH-1:0] load_val_i,
    input  logic                     dir_i,
    input  logic [COUNTER_WIDTH-1:0] step_i,
    input  logic [COUNTER_WIDTH-1:0] max_i,
    input  logic                     sat_i,
    output logic [COUNTER_WIDTH-1:0] count_o,
    output logic                     tc_o,
    output logic                     ovf_o
);

    localparam logic [COUNTER_WIDTH-1:0] RST_VAL = COUNTER_WIDTH'(RESET_VAL);

    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                     tc_q, tc_d;
    logic                     ovf_q, ovf_d;
    logic [COUNTER_WIDTH:0]   sum;
    logic [COUNTER_WIDTH-1:0] diff;

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        sum   = {1'b0, cnt_q} + {1'b0, step_i};
        diff  = cnt_q - step_i;

        if (clr_i) begin
            cnt_d = RST_VAL;
            ovf_d = 1'b0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (step_i != '0)) begin
            if (!dir_i) begin
                // The widened sum also catches a count already above MAX.
                if (sum > {1'b0, max_i}) begin
                    cnt_d = sat_i ? max_i : '0;
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = sum[COUNTER_WIDTH-1:0];
                end
            end else begin
                if (cnt_q < step_i) begin
                    cnt_d = sat_i ? '0 : max_i;
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end else if (diff > max_i) begin
                    // Stepping down from an out-of-range load clamps silently.
                    cnt_d = max_i;
                end else begin
                    cnt_d = diff;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= RST_VAL;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign count_o = cnt_q;
    assign tc_o    = tc_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_step_counter.sv
// Scoreboard bench for step_counter: the stimulus pushes hand-computed expectations,
// and a negedge monitor pops and compares them against the registered outputs.
module tb_step_counter;

    logic       clk_i = 1'b0;
    logic       rst_ni, clr_i, en_i, load_i, dir_i, sat_i;
    logic [7:0] load_val_i, step_i, max_i;
    logic [7:0] count_o;
    logic       tc_o, ovf_o;

    typedef struct {
        int         tag;
        logic [7:0] cnt;
        logic       tc;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   tag    = 0;

    step_counter #(.COUNTER_WIDTH(8), .RESET_VAL(0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .en_i(en_i),
        .load_i(load_i), .load_val_i(load_val_i), .dir_i(dir_i),
        .step_i(step_i), .max_i(max_i), .sat_i(sat_i),
        .count_o(count_o), .tc_o(tc_o), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive one cycle of inputs and queue the outputs expected after that edge.
    task automatic cyc(input logic rst, input logic clr, input logic ld, input logic [7:0] lv,
                       input logic en, input logic dir, input logic [7:0] st,
                       input logic [7:0] mx, input logic sat,
                       input logic [7:0] ec, input logic etc, input logic eovf);
        exp_t e;
        rst_ni = rst; clr_i = clr; load_i = ld; load_val_i = lv;
        en_i = en; dir_i = dir; step_i = st; max_i = mx; sat_i = sat;
        tag = tag + 1;
        e.tag = tag; e.cnt = ec; e.tc = etc; e.ovf = eovf;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks = checks + 3;
            if (count_o !== e.cnt) begin
                errors = errors + 1;
                $display("FAIL count[vec %0d]: got %0d expected %0d", e.tag, count_o, e.cnt);
            end
            if (tc_o !== e.tc) begin
                errors = errors + 1;
                $display("FAIL tc[vec %0d]: got %b expected %b", e.tag, tc_o, e.tc);
            end
            if (ovf_o !== e.ovf) begin
                errors = errors + 1;
                $display("FAIL ovf[vec %0d]: got %b expected %b", e.tag, ovf_o, e.ovf);
            end
        end
    end

    initial begin
        int guard;
        // Reset for 3 cycles
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'd0, 0, 0, 8'd0, 8'd9, 0, 8'd0, 0, 0);

        // Up-count wrap at MAX=9
        for (int i = 1; i <= 12; i++)
            cyc(1, 0, 0, 8'd0, 1, 0, 8'd1, 8'd9, 0, 8'(i % 10), (i == 10), (i >= 10));

        // Saturate with step 3, then clear
        cyc(1, 0, 1, 8'd250, 0, 0, 8'd3, 8'd255, 1, 8'd250, 0, 1);
        cyc(1, 0, 0, 8'd0,   1, 0, 8'd3, 8'd255, 1, 8'd253, 0, 1);
        cyc(1, 0, 0, 8'd0,   1, 0, 8'd3, 8'd255, 1, 8'd255, 1, 1);
        cyc(1, 0, 0, 8'd0,   1, 0, 8'd3, 8'd255, 1, 8'd255, 1, 1);
        cyc(1, 0, 0, 8'd0,   1, 0, 8'd3, 8'd255, 1, 8'd255, 1, 1);
        cyc(1, 1, 0, 8'd0,   1, 0, 8'd3, 8'd255, 1, 8'd0,   0, 0);

        // Down-count wrap to MAX=20
        cyc(1, 0, 1, 8'd5, 0, 1, 8'd2, 8'd20, 0, 8'd5,  0, 0);
        cyc(1, 0, 0, 8'd0, 1, 1, 8'd2, 8'd20, 0, 8'd3,  0, 0);
        cyc(1, 0, 0, 8'd0, 1, 1, 8'd2, 8'd20, 0, 8'd1,  0, 0);
        cyc(1, 0, 0, 8'd0, 1, 1, 8'd2, 8'd20, 0, 8'd20, 1, 1);
        cyc(1, 0, 0, 8'd0, 1, 1, 8'd2, 8'd20, 0, 8'd18, 0, 1);

        // Priority: clear beats load/enable, load beats enable
        cyc(1, 1, 1, 8'd7, 1, 0, 8'd1, 8'd20, 0, 8'd0, 0, 0);
        cyc(1, 0, 1, 8'd7, 1, 0, 8'd1, 8'd20, 0, 8'd7, 0, 0);

        // Out-of-range load
        cyc(1, 0, 1, 8'd50, 0, 0, 8'd1, 8'd10, 0, 8'd50, 0, 0);
        cyc(1, 0, 0, 8'd0,  1, 0, 8'd1, 8'd10, 0, 8'd0,  1, 1);
        cyc(1, 0, 1, 8'd50, 0, 0, 8'd1, 8'd10, 0, 8'd50, 0, 1);
        cyc(1, 0, 0, 8'd0,  1, 1, 8'd1, 8'd10, 0, 8'd10, 0, 1);

        // step 0 and en low hold; MAX=0 boundary both directions
        cyc(1, 0, 0, 8'd0, 1, 0, 8'd0, 8'd10, 0, 8'd10, 0, 1);
        cyc(1, 0, 0, 8'd0, 0, 0, 8'd1, 8'd10, 0, 8'd10, 0, 1);
        cyc(1, 0, 0, 8'd0, 1, 0, 8'd1, 8'd0,  0, 8'd0,  1, 1);
        cyc(1, 0, 0, 8'd0, 1, 0, 8'd1, 8'd0,  0, 8'd0,  1, 1);
        cyc(1, 0, 0, 8'd0, 1, 1, 8'd1, 8'd0,  0, 8'd0,  1, 1);

        // Saturate down to 0
        cyc(1, 1, 0, 8'd0, 0, 0, 8'd1, 8'd255, 1, 8'd0, 0, 0);
        cyc(1, 0, 1, 8'd1, 0, 0, 8'd1, 8'd255, 1, 8'd1, 0, 0);
        cyc(1, 0, 0, 8'd0, 1, 1, 8'd3, 8'd255, 1, 8'd0, 1, 1);

        // Reset mid-operation while saturated high
        cyc(1, 0, 1, 8'd254, 0, 0, 8'd5, 8'd255, 1, 8'd254, 0, 1);
        cyc(1, 0, 0, 8'd0,   1, 0, 8'd5, 8'd255, 1, 8'd255, 1, 1);
        cyc(1, 0, 0, 8'd0,   1, 0, 8'd5, 8'd255, 1, 8'd255, 1, 1);
        cyc(0, 0, 0, 8'd0,   1, 0, 8'd5, 8'd255, 1, 8'd0,   0, 0);
        cyc(1, 0, 0, 8'd0,   1, 0, 8'd1, 8'd255, 1, 8'd1,   0, 0);
        cyc(1, 0, 0, 8'd0,   0, 0, 8'd1, 8'd255, 1, 8'd1,   0, 0);

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk_i);
            guard = guard + 1;
        end
        if (sb.size() > 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
